// File: rtl/request_unit_pkg.sv
// Shared types for the request unit.
//   reqstate_t     : FETCH / DATA / HALT request-sequencing states
//   is_mem_access  : true when the decoded instruction touches data memory
package request_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } reqstate_t;

  localparam int unsigned CNT_W_DEFAULT = 32;

  function automatic logic is_mem_access(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/request_unit_if.sv
// Bundle of the request unit's signals for datapath wiring.
//   ru modport : the request unit's view (decode strobes and hits in, requests out)
//   tb modport : the surrounding datapath / cache view
interface request_unit_if #(
  parameter int unsigned CNT_W = 32
) (
  input logic CLK,
  input logic nRST
);

  logic             iREN;
  logic             dREN;
  logic             dWEN;
  logic             datomic;
  logic             halt;
  logic             ihit;
  logic             dhit;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             dmematomic;
  logic             pc_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport ru (
    input  CLK, nRST, iREN, dREN, dWEN, datomic, halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, dmematomic, pc_en, halted, stall_cnt
  );

  modport tb (
    input  CLK, nRST, imemREN, dmemREN, dmemWEN, dmematomic, pc_en, halted, stall_cnt,
    output iREN, dREN, dWEN, datomic, halt, ihit, dhit
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock and asynchronous active-low clear
//   en         : increment this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Request unit: turns per-instruction decode strobes into held memory
// requests and hands ihit/dhit completion back as a PC enable.
//   CLK, nRST            : clock, asynchronous active-low reset
//   iREN,dREN,dWEN,
//   datomic,halt         : decode strobes from the control unit
//   ihit, dhit           : cache completion strobes
//   imemREN              : instruction read request (combinational)
//   dmemREN,dmemWEN,
//   dmematomic           : held data request, registered
//   pc_en                : one-cycle PC advance pulse (combinational)
//   halted               : sticky halt indication
//   stall_cnt            : saturating count of cycles waiting for dhit
module request_unit
  import request_unit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             datomic,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             dmematomic,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  reqstate_t state;
  logic      stall_en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      dmemREN    <= 1'b0;
      dmemWEN    <= 1'b0;
      dmematomic <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (iREN && ihit) begin
            if (halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (is_mem_access(dREN, dWEN)) begin
              state      <= DATA;
              // A simultaneous read+write decode is illegal; treat it as a write.
              dmemREN    <= dREN & ~dWEN;
              dmemWEN    <= dWEN;
              dmematomic <= datomic;
            end
          end
        end
        DATA: begin
          if (dhit) begin
            state      <= FETCH;
            dmemREN    <= 1'b0;
            dmemWEN    <= 1'b0;
            dmematomic <= 1'b0;
          end
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Combinational outputs are gated by nRST so they read 0 during reset.
  always_comb begin
    imemREN = 1'b0;
    pc_en   = 1'b0;
    if (nRST) begin
      case (state)
        FETCH: begin
          imemREN = iREN;
          pc_en   = iREN & ihit & ~halt & ~is_mem_access(dREN, dWEN);
        end
        DATA:    pc_en = dhit;
        default: ;
      endcase
    end
  end

  assign stall_en = (state == DATA) && !dhit;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (stall_en),
    .count (stall_cnt)
  );

endmodule
